// File: rtl/led_kbd_seg_io_pkg.sv
// Shared constants and the hex-to-seven-segment glyph table for led_kbd_seg_io.
package led_kbd_seg_io_pkg;

    // Start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_IDX_W      = 4;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is always off (1).
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            4'hF:    seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/led_kbd_seg_io_ps2_rx.sv
// PS/2 frame receiver: synchronises the PS/2 lines, samples data on each
// falling ps2_clk edge and emits a one-cycle valid pulse for every frame
// with a correct start bit, stop bit and odd parity.
module ps2_rx
    import led_kbd_seg_io_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       valid
);

    logic [2:0]                clk_sync_reg;
    logic [2:0]                data_sync_reg;
    logic [PS2_IDX_W-1:0]      idx_reg;
    logic [PS2_FRAME_BITS-1:0] frame_reg;
    logic [PS2_FRAME_BITS-1:0] frame_next;
    logic [7:0]                code_reg;
    logic                      valid_reg;
    logic                      fall;
    logic                      last_bit;
    logic                      frame_ok;

    // Falling edge seen between the two oldest clock stages.
    assign fall     = clk_sync_reg[2] & ~clk_sync_reg[1];
    assign last_bit = (idx_reg == PS2_IDX_W'(PS2_FRAME_BITS - 1));
    // Bits arrive LSB first, so shifting right leaves bit 0 = start bit.
    assign frame_next = {data_sync_reg[1], frame_reg[PS2_FRAME_BITS-1:1]};
    // Start low, stop high, odd count of ones across data and parity.
    assign frame_ok   = ~frame_next[0] & frame_next[10] & (^frame_next[9:1]);

    // Three-stage synchronisers; idle level of both lines is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_reg  <= 3'b111;
            data_sync_reg <= 3'b111;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[1:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[1:0], ps2_data};
        end
    end

    // Bit collection and frame validation; a partial frame waits indefinitely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg   <= '0;
            frame_reg <= '0;
            code_reg  <= 8'h00;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (fall) begin
                frame_reg <= frame_next;
                if (last_bit) begin
                    idx_reg <= '0;
                    if (frame_ok) begin
                        code_reg  <= frame_next[8:1];
                        valid_reg <= 1'b1;
                    end
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
        end
    end

    assign code  = code_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/led_kbd_seg_io.sv
// Board I/O peripheral: running-light LEDs, PS/2 keyboard receiver and an
// 8-digit seven-segment display of scan code, frame count, switches, buttons.
module led_kbd_seg_io
    import led_kbd_seg_io_pkg::*;
#(
    parameter int LED_DIV = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn,
    input  logic [7:0]  sw,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] ledr,
    output logic [7:0]  seg0,
    output logic [7:0]  seg1,
    output logic [7:0]  seg2,
    output logic [7:0]  seg3,
    output logic [7:0]  seg4,
    output logic [7:0]  seg5,
    output logic [7:0]  seg6,
    output logic [7:0]  seg7
);

    localparam int DIV_W = (LED_DIV > 2) ? $clog2(LED_DIV) : 1;

    logic [DIV_W-1:0] div_reg;
    logic [15:0]      rot_reg;
    logic [7:0]       code_reg;
    logic [7:0]       count_reg;
    logic [7:0]       rx_code;
    logic             rx_valid;
    logic             div_wrap;
    logic [3:0]       digit_nib [8];
    logic [7:0]       digit_seg [8];

    ps2_rx u_ps2_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .code     (rx_code),
        .valid    (rx_valid)
    );

    assign div_wrap = (div_reg == DIV_W'(LED_DIV - 1));

    // Rotation step divider and the running-light pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg <= '0;
            rot_reg <= 16'h0001;
        end else if (div_wrap) begin
            div_reg <= '0;
            rot_reg <= {rot_reg[14:0], rot_reg[15]};
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    // Latest good scan code and a wrapping count of good frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_reg  <= 8'h00;
            count_reg <= 8'h00;
        end else if (rx_valid) begin
            code_reg  <= rx_code;
            count_reg <= count_reg + 8'h01;
        end
    end

    // Switches and buttons flip individual LEDs of the running light.
    assign ledr = rot_reg ^ {btn, sw, 3'b000};

    assign digit_nib[0] = code_reg[3:0];
    assign digit_nib[1] = code_reg[7:4];
    assign digit_nib[2] = count_reg[3:0];
    assign digit_nib[3] = count_reg[7:4];
    assign digit_nib[4] = sw[3:0];
    assign digit_nib[5] = sw[7:4];
    assign digit_nib[6] = {3'b000, btn[4]};
    assign digit_nib[7] = btn[3:0];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit
            assign digit_seg[gi] = hex_to_seg(digit_nib[gi]);
        end
    endgenerate

    assign seg0 = digit_seg[0];
    assign seg1 = digit_seg[1];
    assign seg2 = digit_seg[2];
    assign seg3 = digit_seg[3];
    assign seg4 = digit_seg[4];
    assign seg5 = digit_seg[5];
    assign seg6 = digit_seg[6];
    assign seg7 = digit_seg[7];

endmodule

// File: tb/tb_led_kbd_seg_io.sv
// Directed bench for led_kbd_seg_io with a short LED divider.
module tb_led_kbd_seg_io;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  btn = '0;
    logic [7:0]  sw = '0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] ledr;
    logic [7:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

    int errors = 0;
    int checks = 0;

    led_kbd_seg_io #(.LED_DIV(4)) dut (
        .clk(clk), .rst(rst), .btn(btn), .sw(sw),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ledr(ledr),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
        .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  sw;
        logic [4:0]  btn;
        logic [15:0] ledr;
        logic [7:0]  s4, s5, s6, s7;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        logic par;
        par = (~^d) ^ bad_par;
        return {stop, par, d, 1'b0};
    endfunction

    // Sends bits [0..nbits-1] of a frame; half = clk cycles per ps2_clk phase.
    task automatic send_bits(input logic [10:0] fr, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (half) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (half) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_disp(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        check({tag, " seg0"}, {8'h00, seg0}, {8'h00, e0});
        check({tag, " seg1"}, {8'h00, seg1}, {8'h00, e1});
        check({tag, " seg2"}, {8'h00, seg2}, {8'h00, e2});
        check({tag, " seg3"}, {8'h00, seg3}, {8'h00, e3});
        $display("%s: seg0..3 = %h %h %h %h", tag, seg0, seg1, seg2, seg3);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] led_seq [9];
        vecs[0] = '{8'h00, 5'h00, 16'h0001, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        vecs[1] = '{8'hA5, 5'h10, 16'h8529, 8'h92, 8'h88, 8'hF9, 8'hC0};
        vecs[2] = '{8'h3C, 5'h0F, 16'h79E1, 8'hC6, 8'hB0, 8'hC0, 8'h8E};
        vecs[3] = '{8'hFF, 5'h1F, 16'hFFF9, 8'h8E, 8'h8E, 8'hF9, 8'h8E};
        vecs[4] = '{8'h12, 5'h05, 16'h2891, 8'hA4, 8'hF9, 8'hC0, 8'h92};
        vecs[5] = '{8'h69, 5'h1A, 16'hD349, 8'h90, 8'h82, 8'hF9, 8'h88};
        vecs[6] = '{8'h7E, 5'h03, 16'h1BF1, 8'h86, 8'hF8, 8'hC0, 8'hB0};
        vecs[7] = '{8'hD4, 5'h14, 16'hA6A1, 8'h99, 8'hA1, 8'hF9, 8'h99};
        vecs[8] = '{8'h8B, 5'h0B, 16'h5C59, 8'h83, 8'h80, 8'hC0, 8'h83};
        led_seq = '{16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h0002,
                    16'h0002, 16'h0002, 16'h0004, 16'h0004};

        // Reset state, checked while rst is still high
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset ledr", ledr, 16'h0001);
        check_disp("reset", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        @(negedge clk);
        rst = 1'b0;

        // Switch/button mapping onto LEDs and digits 4..7
        for (int v = 0; v < 9; v++) begin
            sw  = vecs[v].sw;
            btn = vecs[v].btn;
            do_reset();
            @(negedge clk);
            check($sformatf("vec%0d ledr", v), ledr, vecs[v].ledr);
            check($sformatf("vec%0d seg4", v), {8'h00, seg4}, {8'h00, vecs[v].s4});
            check($sformatf("vec%0d seg5", v), {8'h00, seg5}, {8'h00, vecs[v].s5});
            check($sformatf("vec%0d seg6", v), {8'h00, seg6}, {8'h00, vecs[v].s6});
            check($sformatf("vec%0d seg7", v), {8'h00, seg7}, {8'h00, vecs[v].s7});
            $display("vec%0d sw=%h btn=%h ledr=%h seg4..7=%h %h %h %h",
                     v, sw, btn, ledr, seg4, seg5, seg6, seg7);
        end

        // LED rotation: one step per 4 clocks
        sw = 8'h00;
        btn = 5'h00;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("rotate cycle %0d", k + 1), ledr, led_seq[k]);
            $display("rotate cycle %0d ledr=%h", k + 1, ledr);
        end

        // Good frame 8'h1C at ps2_clk period 40 clk
        do_reset();
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 11, 20);
        check_disp("frame 1C", 8'hC6, 8'hF9, 8'hF9, 8'hC0);

        // Bad parity, then bad stop: nothing changes
        send_bits(make_frame(8'h1C, 1'b1, 1'b1), 11, 20);
        check_disp("bad parity", 8'hC6, 8'hF9, 8'hF9, 8'hC0);
        send_bits(make_frame(8'h5B, 1'b0, 1'b0), 11, 20);
        check_disp("bad stop", 8'hC6, 8'hF9, 8'hF9, 8'hC0);

        // Receiver realigned after rejected frames; ps2_clk held idle changes nothing
        send_bits(make_frame(8'h5B, 1'b0, 1'b1), 11, 20);
        check_disp("frame 5B", 8'h83, 8'h92, 8'hA4, 8'hC0);
        repeat (200) @(negedge clk);
        check_disp("idle hold", 8'h83, 8'h92, 8'hA4, 8'hC0);

        // Reset mid-frame discards the partial frame
        send_bits(make_frame(8'h77, 1'b0, 1'b1), 5, 20);
        do_reset();
        check_disp("mid-frame rst", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 11, 20);
        check_disp("after rst 1C", 8'hC6, 8'hF9, 8'hF9, 8'hC0);

        // Frame count wrap: 254 more frames -> FF, one more -> 00
        for (int f = 0; f < 254; f++)
            send_bits(make_frame(8'hE2, 1'b0, 1'b1), 11, 4);
        check_disp("count FF", 8'hA4, 8'h86, 8'h8E, 8'h8E);
        send_bits(make_frame(8'h30, 1'b0, 1'b1), 11, 4);
        check_disp("count wrap", 8'hC0, 8'hB0, 8'hC0, 8'hC0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
